// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and the
// ALU/load opcode predicate.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_HALTED
    } seq_state_t;

    // Opcodes that read a memory operand and load the accumulator.
    function automatic logic is_alu_ld(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath signal bundle; master is the sequencer side.
interface instr_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             fetch;
    logic [2:0]       opcode;
    logic             zero;
    logic             load_ir;
    logic             inc_pc;
    logic             load_pc;
    logic             load_acc;
    logic             rd;
    logic             wr;
    logic             datactl_ena;
    logic             halt;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  fetch, opcode, zero,
        output load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena,
               halt, instr_done, instr_cnt
    );

    modport slave (
        output fetch, opcode, zero,
        input  load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena,
               halt, instr_done, instr_cnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Eight-step instruction-cycle controller: state register, combinational strobe
// decode, sticky halt and saturating retired-instruction counter.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    instr_sequencer_if.master bus
);

    seq_state_t       state;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            halt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.fetch) state <= ST_S0;
                ST_S0:   state <= ST_S1;
                ST_S1:   state <= ST_S2;
                ST_S2:   state <= ST_S3;
                ST_S3: begin
                    if (bus.opcode == OP_HLT) begin
                        state  <= ST_HALTED;
                        halt_q <= 1'b1;
                        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        state <= ST_S4;
                    end
                end
                ST_S4:   state <= ST_S5;
                ST_S5:   state <= ST_S6;
                ST_S6:   state <= ST_S7;
                ST_S7: begin
                    state <= ST_S0;
                    if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode the current state; opcode/zero only matter from S4 onward.
    always_comb begin
        bus.load_ir     = 1'b0;
        bus.inc_pc      = 1'b0;
        bus.load_pc     = 1'b0;
        bus.load_acc    = 1'b0;
        bus.rd          = 1'b0;
        bus.wr          = 1'b0;
        bus.datactl_ena = 1'b0;
        bus.instr_done  = 1'b0;
        case (state)
            ST_S0, ST_S1: begin
                bus.rd      = 1'b1;
                bus.load_ir = 1'b1;
                bus.inc_pc  = 1'b1;
            end
            ST_S4: begin
                if (is_alu_ld(bus.opcode))    bus.rd          = 1'b1;
                else if (bus.opcode == OP_STO) bus.datactl_ena = 1'b1;
                else if (bus.opcode == OP_JMP) bus.load_pc     = 1'b1;
            end
            ST_S5: begin
                if (is_alu_ld(bus.opcode)) begin
                    bus.rd       = 1'b1;
                    bus.load_acc = 1'b1;
                end else if (bus.opcode == OP_STO) begin
                    bus.datactl_ena = 1'b1;
                    bus.wr          = 1'b1;
                end else if (bus.opcode == OP_JMP) begin
                    bus.load_pc = 1'b1;
                end else if (bus.opcode == OP_SKZ && bus.zero) begin
                    bus.inc_pc = 1'b1;
                end
            end
            ST_S6: begin
                if (is_alu_ld(bus.opcode))    bus.rd          = 1'b1;
                else if (bus.opcode == OP_STO) bus.datactl_ena = 1'b1;
            end
            ST_S7: begin
                bus.instr_done = 1'b1;
                if (bus.opcode == OP_SKZ && bus.zero) bus.inc_pc = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.halt      = halt_q;
    assign bus.instr_cnt = cnt_q;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(bus.rd && bus.wr));
    a_wr_drives:  assert property (@(posedge clk) disable iff (reset) bus.wr |-> bus.datactl_ena);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-state strobe tables for each opcode
// class, halt, mid-instruction reset and counter saturation.
module tb_instr_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic rst4;
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [15:0] exp_cnt;

    instr_sequencer_if #(.CNT_W(16)) bus ();
    instr_sequencer_if #(.CNT_W(4))  bus4 ();

    instr_sequencer #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    instr_sequencer #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst4), .bus(bus4.master));

    always #5 clk = ~clk;

    // {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, instr_done}
    logic [7:0] obs;
    assign obs = {bus.load_ir, bus.inc_pc, bus.load_pc, bus.load_acc,
                  bus.rd, bus.wr, bus.datactl_ena, bus.instr_done};

    task automatic test_reset();
        reset = 1'b1;
        bus.fetch = 1'b0; bus.opcode = OP_ADD; bus.zero = 1'b0;
        #3;
        total_cnt++;
        if ({obs, bus.halt, bus.instr_cnt} !== 25'd0)
            $display("FAIL reset_outputs: got strobes=%b halt=%b cnt=%0d, want all 0", obs, bus.halt, bus.instr_cnt);
        else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        exp_cnt = 16'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (obs !== 8'h00)
                $display("FAIL idle_no_fetch[%0d]: got strobes=%b, want 00000000", i, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_lda();
        logic [7:0] exp [8];
        exp = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                8'b0000_1000, 8'b0001_1000, 8'b0000_1000, 8'b0000_0001};
        @(negedge clk); bus.fetch = 1'b1; bus.opcode = OP_LDA; #1;
        total_cnt++;
        if (obs !== 8'h00) $display("FAIL lda_pre_edge: got strobes=%b, want 00000000", obs);
        else pass_cnt++;
        @(posedge clk); #1; bus.fetch = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            total_cnt++;
            if (obs !== exp[s]) $display("FAIL lda_S%0d: got strobes=%b, want %b", s, obs, exp[s]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        exp_cnt++; #1;
        total_cnt++;
        if (bus.instr_cnt !== exp_cnt) $display("FAIL lda_cnt: got %0d, want %0d", bus.instr_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_sto();
        logic [7:0] exp [8];
        exp = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                8'b0000_0010, 8'b0000_0110, 8'b0000_0010, 8'b0000_0001};
        bus.opcode = OP_STO;
        bus.fetch  = 1'b1;
        for (int s = 0; s < 8; s++) begin
            #1;
            total_cnt++;
            if (obs !== exp[s]) $display("FAIL sto_S%0d: got strobes=%b, want %b", s, obs, exp[s]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        bus.fetch = 1'b0;
        exp_cnt++; #1;
        total_cnt++;
        if (bus.instr_cnt !== exp_cnt) $display("FAIL sto_cnt: got %0d, want %0d", bus.instr_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_skz();
        logic [7:0] exp1 [8];
        logic [7:0] exp0 [8];
        exp1 = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                 8'h00, 8'b0100_0000, 8'h00, 8'b0100_0001};
        exp0 = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'b0000_0001};
        bus.opcode = OP_SKZ;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = (z == 1);
            for (int s = 0; s < 8; s++) begin
                #1;
                total_cnt++;
                if (obs !== ((z == 1) ? exp1[s] : exp0[s]))
                    $display("FAIL skz_z%0d_S%0d: got strobes=%b, want %b", z, s, obs,
                             (z == 1) ? exp1[s] : exp0[s]);
                else pass_cnt++;
                @(posedge clk); #1;
            end
            exp_cnt++;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jmp();
        logic [7:0] exp [8];
        exp = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                8'b0010_0000, 8'b0010_0000, 8'h00, 8'b0000_0001};
        bus.opcode = OP_JMP;
        bus.zero   = 1'b1;
        for (int s = 0; s < 8; s++) begin
            #1;
            total_cnt++;
            if (obs !== exp[s]) $display("FAIL jmp_S%0d: got strobes=%b, want %b", s, obs, exp[s]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        exp_cnt++; #1;
        total_cnt++;
        if ({obs, bus.instr_cnt} !== {8'b1100_1000, exp_cnt})
            $display("FAIL jmp_next_S0: got strobes=%b cnt=%0d, want 11001000 cnt=%0d", obs, bus.instr_cnt, exp_cnt);
        else pass_cnt++;
        bus.zero = 1'b0;
    endtask

    task automatic test_halt();
        logic [2:0] ops [3];
        logic [7:0] alu [8];
        ops = '{OP_ADD, OP_AND, OP_XOR};
        alu = '{8'b1100_1000, 8'b1100_1000, 8'h00, 8'h00,
                8'b0000_1000, 8'b0001_1000, 8'b0000_1000, 8'b0000_0001};
        @(negedge clk); reset = 1'b1; #2; reset = 1'b0;
        @(negedge clk); bus.fetch = 1'b1;
        @(posedge clk); #1; bus.fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.opcode = ops[i];
            for (int s = 0; s < 8; s++) begin
                #1;
                total_cnt++;
                if (obs !== alu[s]) $display("FAIL halt_pre%0d_S%0d: got strobes=%b, want %b", i, s, obs, alu[s]);
                else pass_cnt++;
                @(posedge clk); #1;
            end
        end
        bus.opcode = OP_HLT;
        for (int s = 0; s < 4; s++) begin
            #1;
            total_cnt++;
            if ({bus.halt, obs} !== {1'b0, (s < 2) ? 8'b1100_1000 : 8'h00})
                $display("FAIL hlt_S%0d: got halt=%b strobes=%b", s, bus.halt, obs);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if ({bus.halt, obs, bus.instr_cnt} !== {1'b1, 8'h00, 16'd4})
            $display("FAIL hlt_enter: got halt=%b strobes=%b cnt=%0d, want 1 00000000 4", bus.halt, obs, bus.instr_cnt);
        else pass_cnt++;
        for (int c = 0; c < 100; c++) begin
            bus.fetch  = c[0];
            bus.opcode = 3'($urandom_range(7, 0));
            bus.zero   = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            total_cnt++;
            if ({bus.halt, obs, bus.instr_cnt} !== {1'b1, 8'h00, 16'd4})
                $display("FAIL halted_hold[%0d]: got halt=%b strobes=%b cnt=%0d", c, bus.halt, obs, bus.instr_cnt);
            else pass_cnt++;
        end
        bus.fetch = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        total_cnt++;
        if ({bus.halt, obs, bus.instr_cnt} !== 25'd0)
            $display("FAIL reset_from_halt: got halt=%b strobes=%b cnt=%0d, want all 0", bus.halt, obs, bus.instr_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); reset = 1'b0; bus.opcode = OP_ADD; bus.fetch = 1'b1;
        @(posedge clk); #1; bus.fetch = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        total_cnt++;
        if ({obs, bus.instr_cnt} !== {8'b0001_1000, 16'd1})
            $display("FAIL add_S5: got strobes=%b cnt=%0d, want 00011000 cnt=1", obs, bus.instr_cnt);
        else pass_cnt++;
        reset = 1'b1; #1;
        total_cnt++;
        if ({bus.halt, obs, bus.instr_cnt} !== 25'd0)
            $display("FAIL reset_mid: got halt=%b strobes=%b cnt=%0d, want all 0", bus.halt, obs, bus.instr_cnt);
        else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({obs, bus.instr_cnt} !== 24'd0)
                $display("FAIL post_reset_idle[%0d]: got strobes=%b cnt=%0d, want 0", i, obs, bus.instr_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturate();
        logic [3:0] want;
        @(negedge clk); rst4 = 1'b0; bus4.fetch = 1'b1;
        @(posedge clk); #1; bus4.fetch = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            repeat (8) @(posedge clk);
            #1;
            want = (k > 15) ? 4'd15 : 4'(k);
            total_cnt++;
            if (bus4.instr_cnt !== want)
                $display("FAIL sat_cnt[%0d]: got %0d, want %0d", k, bus4.instr_cnt, want);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst4 = 1'b1;
        bus4.fetch = 1'b0; bus4.opcode = OP_ADD; bus4.zero = 1'b0;
        test_reset();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_halt();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
